// File: rtl/rename_stage.sv
// Register rename stage: speculative RAT, committed CRAT, single-entry output register.
// Optional allocation-stall counter is built when RENAME_PERF_CNT_EN is defined.

package core_pkg;
    localparam int PREGS = 64;
endpackage

module rename_stage #(
    parameter int PHYS_REGS = core_pkg::PREGS,
    parameter int ARCH_REGS = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_rs1,
    input  logic [4:0]                   in_rs2,
    input  logic [4:0]                   in_rd,
    input  logic                         in_rd_we,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(PHYS_REGS)-1:0] out_prs1,
    output logic [$clog2(PHYS_REGS)-1:0] out_prs2,
    output logic [$clog2(PHYS_REGS)-1:0] out_prd,
    output logic [$clog2(PHYS_REGS)-1:0] out_old_prd,
    output logic                         out_rd_we,
    output logic                         alloc_en,
    input  logic [$clog2(PHYS_REGS)-1:0] alloc_phys,
    input  logic                         alloc_valid,
    input  logic                         commit_en,
    input  logic [4:0]                   commit_arch,
    input  logic [$clog2(PHYS_REGS)-1:0] commit_phys,
    input  logic                         flush,
    output logic                         free_en,
    output logic [$clog2(PHYS_REGS)-1:0] free_phys
`ifdef RENAME_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);

    localparam int PW = $clog2(PHYS_REGS);
    localparam logic [4:0] XZR = 5'(ARCH_REGS - 1);

    typedef enum logic {
        IDLE,
        ALLOC
    } state_t;

    state_t        state;
    logic [PW-1:0] rat       [ARCH_REGS];
    logic [PW-1:0] crat      [ARCH_REGS];
    logic [PW-1:0] crat_next [ARCH_REGS];
    logic [4:0]    rd_p1;

    logic accept;
    logic need_dest;
    logic commit_ok;
    logic lost_held;
    logic lost_alloc;

    always_comb begin
        in_ready   = (state == IDLE) && !flush && (!out_valid || out_ready);
        accept     = in_valid && in_ready;
        need_dest  = in_rd_we && (in_rd != XZR);
        commit_ok  = commit_en && (commit_arch != XZR);
        lost_held  = out_valid && out_rd_we;
        lost_alloc = (state == ALLOC) && alloc_valid;
    end

    // The allocate request for a destination goes out in the accept cycle so the
    // free-list answer lands in the single ALLOC cycle that follows.
    always_comb begin
        alloc_en = 1'b0;
        if (!reset && !flush) begin
            if (state == ALLOC)
                alloc_en = !alloc_valid;
            else
                alloc_en = accept && need_dest;
        end
    end

    // Flush restores from the committed map including a same-cycle commit.
    always_comb begin
        crat_next = crat;
        if (commit_ok)
            crat_next[commit_arch] = commit_phys;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_prs1    <= '0;
            out_prs2    <= '0;
            out_prd     <= '0;
            out_old_prd <= '0;
            out_rd_we   <= 1'b0;
            free_en     <= 1'b0;
            free_phys   <= '0;
            rd_p1       <= '0;
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat[i]  <= PW'(i);
                crat[i] <= PW'(i);
            end
        end else begin
            free_en <= 1'b0;
            crat    <= crat_next;
            if (commit_ok) begin
                free_en   <= 1'b1;
                free_phys <= crat[commit_arch];
            end

            if (flush) begin
                rat       <= crat_next;
                out_valid <= 1'b0;
                state     <= IDLE;
                if (lost_held) begin
                    free_en   <= 1'b1;
                    free_phys <= out_prd;
                end else if (lost_alloc) begin
                    free_en   <= 1'b1;
                    free_phys <= alloc_phys;
                end
            end else begin
                if (out_valid && out_ready)
                    out_valid <= 1'b0;

                case (state)
                    // p0 -> p1: sources read from the RAT in the accept cycle
                    IDLE: begin
                        if (accept) begin
                            out_prs1 <= rat[in_rs1];
                            out_prs2 <= rat[in_rs2];
                            if (need_dest) begin
                                rd_p1 <= in_rd;
                                state <= ALLOC;
                            end else begin
                                out_prd     <= '0;
                                out_old_prd <= '0;
                                out_rd_we   <= 1'b0;
                                out_valid   <= 1'b1;
                            end
                        end
                    end
                    // p1 -> p2: destination mapped once the free list answers
                    ALLOC: begin
                        if (alloc_valid) begin
                            rat[rd_p1]  <= alloc_phys;
                            out_prd     <= alloc_phys;
                            out_old_prd <= rat[rd_p1];
                            out_rd_we   <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef RENAME_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (in_valid && !in_ready)
            stall_cycles <= sat_inc(stall_cycles);
    end
`endif

endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 SHALL have parameters: PHYS_REGS, default core_pkg::PREGS, physical register count; ARCH_REGS, default 32, architectural register count (X31 = XZR).
REQ-002 SHALL use one clock; reset is synchronous and active-high. Ports are listed below.
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid / in_ready  input / output  1 / 1  decoded-instruction handshake
in_rs1, in_rs2, in_rd  input  5 each  architectural sources / destination
in_rd_we  input  1  instruction writes rd
out_valid / out_ready  output / input  1 / 1  renamed-instruction handshake (to ROB/dispatch)
out_prs1, out_prs2, out_prd, out_old_prd  output  6 each  physical sources, new dest, previous dest mapping
out_rd_we  output  1  renamed instruction has a destination
alloc_en  output  1  free-list allocate request
alloc_phys  input  6  free-list result
alloc_valid  input  1  free-list result valid (one cycle after alloc_en)
commit_en  input  1  ROB commits a destination
commit_arch  input  5  committed architectural register
commit_phys  input  6  committed physical register
flush  input  1  squash speculative state
free_en  output  1  release request to free list
free_phys  output  6  register released
stall_cycles  output  32  allocation-stall counter (RENAME_PERF_CNT_EN only)

Function
REQ-003 SHALL hold a speculative map RAT and a committed map CRAT, each ARCH_REGS x 6 bits.
REQ-004 SHALL treat an instruction as needing a destination iff in_rd_we=1 and in_rd!=31; otherwise out_rd_we=0 and out_prd=out_old_prd=0.
REQ-005 SHALL implement states IDLE, ALLOC.
REQ-006 in_ready SHALL be 1 iff state=IDLE, flush=0, and (out_valid=0 or out_ready=1).
REQ-007 On accept (in_valid&in_ready), SHALL capture out_prs1=RAT[in_rs1] and out_prs2=RAT[in_rs2] from the RAT value in the accept cycle.
REQ-008 On accept of a no-destination instruction, SHALL set out_valid at the next edge and stay IDLE; throughput 1/cycle.
REQ-009 On accept of a destination instruction, SHALL assert alloc_en combinationally in that cycle, capture the instruction, and enter ALLOC.
REQ-010 In ALLOC with alloc_valid=1, SHALL, at the edge: write RAT[rd]=alloc_phys, set out_prd=alloc_phys, out_old_prd=the prior RAT[rd], out_valid=1, and state=IDLE. Accept-to-out_valid latency is 2 cycles.
REQ-011 In ALLOC with alloc_valid=0 (free list empty), SHALL re-assert alloc_en in that cycle and remain in ALLOC indefinitely.
REQ-012 alloc_en SHALL be 0 whenever flush=1 or reset=1.
REQ-013 Output fields SHALL hold stable while out_valid=1 and out_ready=0. out_valid SHALL clear on out_ready=1 unless a new result loads.
REQ-014 A following instruction SHALL observe the preceding RAT write without a bypass path, because in_ready is low during ALLOC.
REQ-015 On commit_en with commit_arch!=31, SHALL register free_en=1, free_phys=CRAT[commit_arch] and set CRAT[commit_arch]=commit_phys. commit_arch=31 SHALL be ignored.
REQ-016 On flush, at the edge, SHALL:
- copy CRAT (including any same-cycle commit update) into RAT;
- clear out_valid;
- return the state to IDLE.
REQ-017 On flush, SHALL register free_en/free_phys for the lost register: the held out_prd if out_valid&out_rd_we, else alloc_phys if state=ALLOC and alloc_valid=1. These two cases are mutually exclusive.
REQ-018 Flush free SHALL override commit free in the same cycle. Integration guarantees commit_en=0 during flush.
REQ-019 free_en SHALL be high for exactly one cycle per release; it defaults to 0.

Reset
REQ-020 Reset SHALL set RAT[i]=CRAT[i]=i, state=IDLE, out_valid=0, all out_* fields=0, free_en=0, free_phys=0, and stall_cycles=0.
REQ-021 Reset mid-ALLOC SHALL abandon the pending allocation with no free issued.

Configuration
REQ-022 With RENAME_PERF_CNT_EN defined:
- stall_cycles SHALL increment (saturating) each cycle in_valid=1 and in_ready=0;
- stall_cycles SHALL clear on reset.
REQ-023 Without RENAME_PERF_CNT_EN, the stall_cycles port and its counter SHALL be absent.

Verification
REQ-024 Reset; rename X1<-X2,X3 (rd_we), alloc_phys=40 -> out_valid 2 cycles after accept; prs1=2, prs2=3, prd=40, old_prd=1.
REQ-025 Next instruction reads X1, writes X5 with alloc_phys=41 -> prs1=40, prd=41, old_prd=5.
REQ-026 alloc_valid=0 for 3 cycles -> alloc_en high all 4 cycles, in_ready=0, success on the 4th with the correct prd.
REQ-027 commit X1->40 -> free_en pulse next cycle, free_phys=1; a later commit X1->44 -> free_phys=40.
REQ-028 Held output (X2->41) with out_ready=0, then flush -> out_valid=0, free_phys=41, next read of X2 gives CRAT value 2.
REQ-029 out_ready=0 for 5 cycles -> outputs stable, in_ready=0; RD to XZR yields out_rd_we=0 and no alloc_en.
